iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Self-contained, parametrised radix-2 restoring divider for the execute stage.
- Replaces the vendor-IP-backed 32-bit divider. Adds:
  - signed and unsigned modes
  - selectable quotient or remainder output
  - fixed divide-by-zero and signed-overflow results
  - a short path for those special cases
- Keeps the same level-based enabled/completed handshake, so the execute-unit sequencing logic is unchanged.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 2..64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- is_signed  in  1  1 = two's-complement operands (DIV/REM); 0 = unsigned (DIVU/REMU).
- rem_sel  in  1  1 = c returns remainder; 0 = c returns quotient.
- enabled  in  1  request level; held high until completed is seen; dropping it aborts or clears.
- c  out  WIDTH  result; valid while completed=1.
- completed  out  1  result valid; held high while enabled stays high.
- div_by_zero  out  1  set with completed when b was 0; cleared with completed.

Behaviour:
Reset (rst_n=0, asynchronous, any state):
- state=IDLE; c=0; completed=0; div_by_zero=0.
- Counter, partial remainder and quotient registers are cleared.
- Reset mid-division discards the operation; nothing is emitted afterward.

States: IDLE, DIVIDE, FIXUP, DONE.

IDLE:
- Stays in IDLE while enabled=0.
- Edge 0 is the first rising edge with enabled=1. At edge 0 it latches a, b, is_signed, rem_sel.
- Later changes on those inputs are ignored until the next return to IDLE.
- Special-case checks at edge 0:
  - b==0: go to DONE. c = rem_sel ? a : all-ones. div_by_zero=1. completed=1 visible after edge 0.
  - is_signed, a==1<<(WIDTH-1) and b==all-ones (overflow): go to DONE. c = rem_sel ? 0 : a. completed=1 after edge 0.
  - Otherwise: store |a| and |b| (absolute values when is_signed, raw values when not), quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB] (both signs forced 0 when unsigned). Load counter with WIDTH and go to DIVIDE.

DIVIDE:
- One quotient bit per cycle, MSB first.
- Per cycle: shift {rem,quo} left by 1. If rem_shifted >= |b|, subtract and set the quotient LSB to 1.
- Partial remainder is WIDTH+1 bits so no carry is lost.
- Decrement the counter; go to FIXUP when the counter reaches 1 on this edge.
- Exactly WIDTH cycles are spent in DIVIDE, at edges 1..WIDTH.

FIXUP (edge WIDTH+1):
- Apply sign negation to the selected result and write c.
- Set completed=1 and go to DONE.
- Normal latency: completed is visible after edge WIDTH+1, i.e. WIDTH+2 enabled cycles.

DONE:
- Holds c, completed and div_by_zero while enabled=1.
- enabled=0 at an edge: go to IDLE; completed=0, div_by_zero=0; c keeps its value.

Abort:
- enabled=0 in DIVIDE or FIXUP: go to IDLE at that edge; completed stays 0; no result is written.

Back-to-back operation:
- A new operation needs at least one edge with enabled=0.
- completed never rises on the same edge that enabled falls.

Result semantics:
- Quotient truncates toward zero.
- Remainder carries the sign of the dividend.
- Invariant: a == q*b + r in WIDTH-bit arithmetic, for all non-zero b.

Test Plan:
- WIDTH=32, unsigned, a=100, b=7 -> quotient c=14 (rem_sel=0), remainder c=2 (rem_sel=1); completed rises exactly after edge 33 and holds until enabled drops.
- WIDTH=32, signed, a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); a=7, b=-2 -> quotient -3, remainder 1.
- Divide by zero: a=0x1234, b=0, both modes -> quotient 0xFFFFFFFF, remainder 0x1234; div_by_zero=1; completed after edge 0.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF, is_signed=1 -> quotient 0x80000000, remainder 0, div_by_zero=0, completed after edge 0. Same operands unsigned -> quotient 0, remainder 0x80000000 after the full latency.
- Abort and reset: drop enabled at edge 10 -> completed stays 0 and the next request yields the correct fresh result. Pulse rst_n low mid-DIVIDE -> outputs clear immediately without waiting for a clock.
- Parameter sweep: WIDTH=8 and WIDTH=64 with random operands, checked against a reference model using the a==q*b+r invariant; latency WIDTH+2 confirmed.

Source files
------------

// File: rtl/iterative_divider.sv
// iterative_divider
//   Radix-2 restoring divider for the execute stage. One quotient bit is
//   produced per clock, MSB first. Both signed and unsigned division are
//   supported, and the result can be either the quotient or the remainder.
//   Divide-by-zero and signed overflow skip the iteration entirely and
//   return fixed results.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   a, b         dividend / divisor (WIDTH bits), latched on the first enabled edge
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   rem_sel      1 = c returns remainder, 0 = c returns quotient
//   enabled      request level; hold high until completed; dropping it aborts/clears
//   c            result, valid while completed=1
//   completed    result valid; held while enabled stays high
//   div_by_zero  set together with completed when b was zero
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             rem_sel,
  input  logic             enabled,
  output logic [WIDTH-1:0] c,
  output logic             completed,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIXUP,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   rem_q;      // partial remainder, one spare bit for the shift carry
  logic [WIDTH-1:0] quo_q;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             sel_rem_q;

  logic             a_neg, b_neg, b_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] res_raw, res_fix;
  logic             res_neg;

  always_comb begin
    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    a_mag   = a_neg ? ('0 - a) : a;
    b_mag   = b_neg ? ('0 - b) : b;
    b_zero  = (b == '0);
    ovf     = is_signed & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);

    // Shift {rem,quo} left by one; the dividend MSB enters the remainder.
    rem_sh  = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});

    res_raw = sel_rem_q ? rem_q[WIDTH-1:0] : quo_q;
    res_neg = sel_rem_q ? r_neg_q : q_neg_q;
    res_fix = res_neg ? ('0 - res_raw) : res_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (enabled) state_nxt = (b_zero | ovf) ? DONE : DIVIDE;
      DIVIDE: if (!enabled) state_nxt = IDLE;
              else if (cnt_q == CW'(1)) state_nxt = FIXUP;
      FIXUP:  state_nxt = enabled ? DONE : IDLE;
      DONE:   if (!enabled) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      sel_rem_q   <= 1'b0;
      c           <= '0;
      completed   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enabled) begin
            if (b_zero) begin
              c           <= rem_sel ? a : '1;
              completed   <= 1'b1;
              div_by_zero <= 1'b1;
            end else if (ovf) begin
              c           <= rem_sel ? '0 : a;
              completed   <= 1'b1;
            end else begin
              rem_q     <= '0;
              quo_q     <= a_mag;
              dvs_q     <= b_mag;
              q_neg_q   <= a_neg ^ b_neg;
              r_neg_q   <= a_neg;
              sel_rem_q <= rem_sel;
              cnt_q     <= CW'(WIDTH);
            end
          end
        end
        DIVIDE: begin
          if (enabled) begin
            rem_q <= fits ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIXUP: begin
          if (enabled) begin
            c         <= res_fix;
            completed <= 1'b1;
          end
        end
        DONE: begin
          if (!enabled) begin
            completed   <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] a64, b64;
  logic        is_s, rsel;
  logic        en   [3];
  logic [63:0] cw   [3];
  logic        cmp  [3];
  logic        dbz  [3];
  int          wid  [3] = '{32, 8, 64};

  logic [31:0] c32;
  logic [7:0]  c8;
  logic [63:0] c64;
  logic        cm32, cm8, cm64, dz32, dz8, dz64;

  iterative_divider #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst_n(rst_n), .a(a64[31:0]), .b(b64[31:0]), .is_signed(is_s),
    .rem_sel(rsel), .enabled(en[0]), .c(c32), .completed(cm32), .div_by_zero(dz32));
  iterative_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .a(a64[7:0]), .b(b64[7:0]), .is_signed(is_s),
    .rem_sel(rsel), .enabled(en[1]), .c(c8), .completed(cm8), .div_by_zero(dz8));
  iterative_divider #(.WIDTH(64)) u_div64 (
    .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .is_signed(is_s),
    .rem_sel(rsel), .enabled(en[2]), .c(c64), .completed(cm64), .div_by_zero(dz64));

  assign cw[0] = {32'd0, c32};
  assign cw[1] = {56'd0, c8};
  assign cw[2] = c64;
  assign cmp[0] = cm32;
  assign cmp[1] = cm8;
  assign cmp[2] = cm64;
  assign dbz[0] = dz32;
  assign dbz[1] = dz8;
  assign dbz[2] = dz64;

  typedef struct {
    logic [63:0] c;
    logic        dbz;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q [3][$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned en_edges [3] = '{0, 0, 0};
  logic        prev_cmp [3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [63:0] mask(int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] minv(int w);
    return 64'd1 << (w - 1);
  endfunction

  // Reference: SV integer division truncates toward zero and the remainder
  // takes the dividend's sign, matching the required semantics.
  function automatic logic [63:0] model(int w, logic [63:0] av_i, logic [63:0] bv_i,
                                        logic s, logic r);
    logic [63:0] m, av, bv, res;
    longint      sa, sd;
    m  = mask(w);
    av = av_i & m;
    bv = bv_i & m;
    if (bv == 64'd0) return r ? av : m;
    if (s && av == minv(w) && bv == m) return r ? 64'd0 : av;
    if (s) begin
      sa  = av << (64 - w);
      sa  = sa >>> (64 - w);
      sd  = bv << (64 - w);
      sd  = sd >>> (64 - w);
      res = r ? (sa % sd) : (sa / sd);
    end else begin
      res = r ? (av % bv) : (av / bv);
    end
    return res & m;
  endfunction

  // Enabled-edge counter per instance: value seen at the negedge after edge k is k+1.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) en_edges[i] = en[i] ? en_edges[i] + 1 : 0;
  end

  // Monitor: pops one expectation per rising completed.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (cmp[i] === 1'b1 && prev_cmp[i] !== 1'b1) begin
        if (exp_q[i].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_completed_w%0d: got 1 expected 0", wid[i]);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("c_w%0d", wid[i]), cw[i], e.c);
          chk($sformatf("dbz_w%0d", wid[i]), {63'd0, dbz[i]}, {63'd0, e.dbz});
          chk($sformatf("latency_w%0d", wid[i]), 64'(en_edges[i]), 64'(e.lat));
        end
      end
      prev_cmp[i] = cmp[i];
    end
  end

  task automatic start(int id, logic [63:0] av, logic [63:0] bv, logic s, logic r);
    @(negedge clk);
    a64    = av;
    b64    = bv;
    is_s   = s;
    rsel   = r;
    en[id] = 1'b1;
  endtask

  task automatic issue(int id, logic [63:0] av, logic [63:0] bv, logic s, logic r,
                       logic [63:0] ec, logic edbz);
    int          w;
    logic [63:0] m;
    logic        special, seen;
    exp_t        e;
    w       = wid[id];
    m       = mask(w);
    special = ((bv & m) == 64'd0) || (s && (av & m) == minv(w) && (bv & m) == m);
    e.c     = ec;
    e.dbz   = edbz;
    e.lat   = special ? 1 : w + 2;
    exp_q[id].push_back(e);
    start(id, av, bv, s, r);
    @(negedge clk);
    // Operand changes after the first edge must not affect the result.
    a64  = ~av;
    b64  = 64'h5;
    is_s = ~s;
    rsel = ~r;
    seen = 1'b0;
    for (int k = 0; k < w + 8 && !seen; k++) begin
      if (cmp[id] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_w%0d: got completed=0 expected 1", w);
      if (exp_q[id].size() != 0) void'(exp_q[id].pop_back());
    end else begin
      repeat (2) @(negedge clk);
      chk("completed_hold", {63'd0, cmp[id]}, 64'd1);
      chk("c_hold", cw[id], ec);
    end
    en[id] = 1'b0;
    @(negedge clk);
    chk("completed_clear", {63'd0, cmp[id]}, 64'd0);
    chk("dbz_clear", {63'd0, dbz[id]}, 64'd0);
    if (seen) chk("c_keep", cw[id], ec);
  endtask

  task automatic rand_op(int id);
    logic [63:0] av, bv;
    logic        s, r;
    av = {$urandom, $urandom};
    bv = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) bv = bv >> $urandom_range(0, wid[id] - 2);
    s  = 1'($urandom_range(0, 1));
    r  = 1'($urandom_range(0, 1));
    issue(id, av & mask(wid[id]), bv & mask(wid[id]), s, r,
          model(wid[id], av, bv, s, r), (bv & mask(wid[id])) == 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a64 = '0; b64 = '0; is_s = 1'b0; rsel = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("reset_c", cw[i], 64'd0);
      chk("reset_completed", {63'd0, cmp[i]}, 64'd0);
      chk("reset_dbz", {63'd0, dbz[i]}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=32 directed
    issue(0, 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 1'b0);
    issue(0, 64'd100, 64'd7, 1'b0, 1'b1, 64'd2, 1'b0);
    issue(0, 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFD, 1'b0);
    issue(0, 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b1, 64'hFFFF_FFFF, 1'b0);
    issue(0, 64'd7, 64'hFFFF_FFFE, 1'b1, 1'b0, 64'hFFFF_FFFD, 1'b0);
    issue(0, 64'd7, 64'hFFFF_FFFE, 1'b1, 1'b1, 64'd1, 1'b0);
    issue(0, 64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF, 1'b1);
    issue(0, 64'h1234, 64'd0, 1'b0, 1'b1, 64'h1234, 1'b1);
    issue(0, 64'h1234, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF, 1'b1);
    issue(0, 64'h1234, 64'd0, 1'b1, 1'b1, 64'h1234, 1'b1);
    issue(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000, 1'b0);
    issue(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 64'd0, 1'b0);
    issue(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0, 64'd0, 1'b0);
    issue(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b1, 64'h8000_0000, 1'b0);
    issue(0, 64'd5, 64'd9, 1'b0, 1'b0, 64'd0, 1'b0);
    issue(0, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'hFFFF_FFFF, 1'b0);

    // Abort: enabled high for edges 0..9, low at edge 10
    start(0, 64'd999, 64'd10, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    en[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_completed", {63'd0, cmp[0]}, 64'd0);
    end
    issue(0, 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 1'b0);

    // Asynchronous reset mid-DIVIDE
    start(0, 64'd200, 64'd3, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_c", cw[0], 64'd0);
    chk("async_rst_completed", {63'd0, cmp[0]}, 64'd0);
    en[0] = 1'b0;
    #1 rst_n = 1'b1;
    issue(0, 64'd200, 64'd3, 1'b0, 1'b1, 64'd2, 1'b0);

    // WIDTH=8
    issue(1, 64'd200, 64'd7, 1'b0, 1'b0, 64'd28, 1'b0);
    issue(1, 64'h80, 64'hFF, 1'b1, 1'b0, 64'h80, 1'b0);
    issue(1, 64'h55, 64'd0, 1'b0, 1'b1, 64'h55, 1'b1);
    for (int n = 0; n < 6; n++) rand_op(1);

    // WIDTH=64
    issue(2, 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    issue(2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, '1, 1'b0);
    for (int n = 0; n < 6; n++) rand_op(2);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("pending_expectations", 64'(exp_q[i].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
